// File: rtl/mc_hazard_scoreboard_pkg.sv
// Shared encodings for the multi-cycle hazard scoreboard: unit FSM states,
// special register indices and unit slot numbers.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } unit_state_e;

  localparam logic [5:0] REG_HI = 6'd32;
  localparam logic [5:0] REG_LO = 6'd33;

  localparam int unsigned UNIT_MUL = 0;
  localparam int unsigned UNIT_DIV = 1;

endpackage

// File: rtl/mc_hazard_scoreboard_tracker.sv
// mc_unit_tracker: state, latency countdown and destination latch for one
// multi-cycle unit, plus its protocol-error detection.
module mc_unit_tracker #(
  parameter int unsigned REG_AW = 6,
  parameter int unsigned LAT_W  = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_dst,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic              flush,
  input  logic              wb_ack,
  output logic              busy,
  output logic              rdy,
  output logic              pend_vld,
  output logic [REG_AW-1:0] pend_dst,
  output logic              err
);
  import hazard_pkg::*;

  unit_state_e       state;
  logic [LAT_W-1:0]  cnt;
  logic [REG_AW-1:0] dst;
  logic              take;

  assign take = issue_valid && !flush && (state == IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      dst   <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          dst   <= issue_dst;
          cnt   <= issue_lat;
          state <= (issue_lat == '0) ? WB : BUSY;
        end
        BUSY: begin
          if (cnt != '0) cnt <= cnt - LAT_W'(1);
          if (cnt <= LAT_W'(1)) state <= WB;
        end
        WB:      if (wb_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign rdy  = (state == WB);

  // An issuing unit contributes its incoming dst; a unit acked in WB is forwarded from W.
  assign pend_dst = (state == IDLE) ? issue_dst : dst;
  assign pend_vld = (state == IDLE) ? (take && (issue_dst != '0))
                                    : ((dst != '0) && !((state == WB) && wb_ack));

  assign err = (wb_ack && (state != WB)) || (issue_valid && !flush && (state != IDLE));

endmodule

// File: rtl/mc_hazard_scoreboard.sv
// Per-unit, per-destination hazard scoreboard for multi-cycle units.
// Optional stall performance counters are built when HAZ_PERF_CNT_EN is defined.
module mc_hazard_scoreboard #(
  parameter int unsigned NUM_UNITS = 2,
  parameter int unsigned REG_AW    = 6,
  parameter int unsigned LAT_W     = 6
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_UNITS-1:0]          issue_valid_E,
  input  logic [NUM_UNITS*REG_AW-1:0]   issue_dst_E,
  input  logic [NUM_UNITS*LAT_W-1:0]    issue_lat_E,
  input  logic                          flush_E,
  input  logic [NUM_UNITS-1:0]          wb_ack_W,
  input  logic [REG_AW-1:0]             RsD,
  input  logic [REG_AW-1:0]             RtD,
  input  logic                          use_rs_D,
  input  logic                          use_rt_D,
  input  logic [REG_AW-1:0]             dst_D,
  input  logic [NUM_UNITS-1:0]          unit_sel_D,
  output logic                          StallF,
  output logic                          StallD,
  output logic                          FlushE,
  output logic [NUM_UNITS-1:0]          unit_busy,
  output logic [NUM_UNITS-1:0]          result_rdy,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   struct_stall_cycles,
`endif
  output logic                          proto_err
);

  logic [NUM_UNITS-1:0] pend_vld;
  logic [REG_AW-1:0]    pend_dst [NUM_UNITS];
  logic [NUM_UNITS-1:0] unit_err;
  logic                 multi_issue;
  logic                 raw, waw, struct_hz, stall;

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
    mc_unit_tracker #(.REG_AW(REG_AW), .LAT_W(LAT_W)) u_trk (
      .CLK        (CLK),
      .RST        (RST),
      .issue_valid(issue_valid_E[g]),
      .issue_dst  (issue_dst_E[g*REG_AW +: REG_AW]),
      .issue_lat  (issue_lat_E[g*LAT_W +: LAT_W]),
      .flush      (flush_E),
      .wb_ack     (wb_ack_W[g]),
      .busy       (unit_busy[g]),
      .rdy        (result_rdy[g]),
      .pend_vld   (pend_vld[g]),
      .pend_dst   (pend_dst[g]),
      .err        (unit_err[g])
    );
  end

  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (pend_vld[i]) begin
        if (use_rs_D && (RsD != '0) && (RsD == pend_dst[i])) raw = 1'b1;
        if (use_rt_D && (RtD != '0) && (RtD == pend_dst[i])) raw = 1'b1;
        if ((dst_D != '0) && (dst_D == pend_dst[i]))         waw = 1'b1;
      end
    end
  end

  assign struct_hz   = |(unit_sel_D & (unit_busy | issue_valid_E));
  assign stall       = raw | waw | struct_hz;
  assign StallF      = stall;
  assign StallD      = stall;
  assign FlushE      = stall;
  assign multi_issue = (issue_valid_E & (issue_valid_E - NUM_UNITS'(1))) != '0;

  always_ff @(posedge CLK) begin
    if (RST) proto_err <= 1'b0;
    else if ((|unit_err) || multi_issue) proto_err <= 1'b1;
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles        <= '0;
      struct_stall_cycles <= '0;
    end else begin
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (struct_hz && (struct_stall_cycles != '1))
        struct_stall_cycles <= struct_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_hazard_scoreboard.sv
// Directed bench for mc_hazard_scoreboard; expectations queued at drive time, checked at negedge.
module tb_mc_hazard_scoreboard;
  import hazard_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  issue_valid_E;
  logic [11:0] issue_dst_E;
  logic [11:0] issue_lat_E;
  logic        flush_E;
  logic [1:0]  wb_ack_W;
  logic [5:0]  RsD, RtD, dst_D;
  logic        use_rs_D, use_rt_D;
  logic [1:0]  unit_sel_D;
  logic        StallF, StallD, FlushE, proto_err;
  logic [1:0]  unit_busy, result_rdy;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles, struct_stall_cycles;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  string       q_tag [$];
  logic [7:0]  q_exp [$];

  always #5 CLK = ~CLK;

  mc_hazard_scoreboard #(.NUM_UNITS(2), .REG_AW(6), .LAT_W(6)) dut (
    .CLK(CLK), .RST(RST),
    .issue_valid_E(issue_valid_E), .issue_dst_E(issue_dst_E), .issue_lat_E(issue_lat_E),
    .flush_E(flush_E), .wb_ack_W(wb_ack_W),
    .RsD(RsD), .RtD(RtD), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
    .dst_D(dst_D), .unit_sel_D(unit_sel_D),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .unit_busy(unit_busy), .result_rdy(result_rdy),
`ifdef HAZ_PERF_CNT_EN
    .stall_cycles(stall_cycles), .struct_stall_cycles(struct_stall_cycles),
`endif
    .proto_err(proto_err)
  );

  function automatic logic [7:0] ev(input logic s, input logic [1:0] b,
                                    input logic [1:0] r, input logic e);
    return {s, s, s, b, r, e};
  endfunction

  task automatic check_one();
    string      tag;
    logic [7:0] exp, obs;
    tag = q_tag.pop_front();
    exp = q_exp.pop_front();
    obs = {StallF, StallD, FlushE, unit_busy, result_rdy, proto_err};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b (StallF,StallD,FlushE,busy[1:0],rdy[1:0],err)",
             tag, obs, exp);
    end
  endtask

  // Queue the expectation for this cycle, check mid-cycle, then advance past the edge.
  task automatic cyc(input string tag, input logic [7:0] exp);
    q_tag.push_back(tag);
    q_exp.push_back(exp);
    @(negedge CLK);
    check_one();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; issue_valid_E = '0; issue_dst_E = '0; issue_lat_E = '0;
    flush_E = 1'b0; wb_ack_W = '0; RsD = '0; RtD = '0; dst_D = '0;
    use_rs_D = 1'b0; use_rt_D = 1'b0; unit_sel_D = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    cyc("reset", ev(0, 2'b00, 2'b00, 0));

    // MUL -> LO, latency 4, dependent read from the following cycle
    issue_valid_E = 2'b01; issue_dst_E[5:0] = REG_LO; issue_lat_E[5:0] = 6'd4;
    cyc("t1_issue", ev(0, 2'b00, 2'b00, 0));
    issue_valid_E = '0; use_rs_D = 1'b1; RsD = REG_LO;
    for (int i = 0; i < 4; i++) cyc("t1_busy", ev(1, 2'b01, 2'b00, 0));
    cyc("t1_wb_wait", ev(1, 2'b01, 2'b01, 0));
    wb_ack_W = 2'b01;
    cyc("t1_ack", ev(0, 2'b01, 2'b01, 0));
    wb_ack_W = '0;
    cyc("t1_idle", ev(0, 2'b00, 2'b00, 0));
`ifdef HAZ_PERF_CNT_EN
    total++;
    assert (stall_cycles === 32'd5) else begin
      bad++; $error("FAIL perf_stall observed=%0d expected=5", stall_cycles);
    end
    total++;
    assert (struct_stall_cycles === 32'd0) else begin
      bad++; $error("FAIL perf_struct observed=%0d expected=0", struct_stall_cycles);
    end
`endif
    use_rs_D = 1'b0;

    // DIV -> HI, latency 10; same-cycle dependent read hits the bypass
    issue_valid_E = 2'b10; issue_dst_E[11:6] = REG_HI; issue_lat_E[11:6] = 6'd10;
    use_rt_D = 1'b1; RtD = REG_HI;
    cyc("t2_bypass", ev(1, 2'b00, 2'b00, 0));
    issue_valid_E = '0; use_rs_D = 1'b1; RsD = 6'd5; RtD = 6'd6;
    for (int i = 0; i < 4; i++) cyc("t2_unrelated", ev(0, 2'b10, 2'b00, 0));
    unit_sel_D = 2'b10;
    for (int i = 0; i < 3; i++) cyc("t3_struct", ev(1, 2'b10, 2'b00, 0));
    unit_sel_D = 2'b01;
    for (int i = 0; i < 3; i++) cyc("t3_other_unit", ev(0, 2'b10, 2'b00, 0));
    unit_sel_D = 2'b10;
    cyc("t2_rdy", ev(1, 2'b10, 2'b10, 0));
    wb_ack_W = 2'b10;
    cyc("t3_ack", ev(1, 2'b10, 2'b10, 0));
    wb_ack_W = '0;
    cyc("t3_idle", ev(0, 2'b00, 2'b00, 0));
    unit_sel_D = '0; use_rs_D = 1'b0; use_rt_D = 1'b0;

    // flushed issue is cancelled, then a zero-latency issue
    issue_valid_E = 2'b01; flush_E = 1'b1; issue_dst_E[5:0] = REG_LO; issue_lat_E[5:0] = 6'd3;
    use_rs_D = 1'b1; RsD = REG_LO;
    cyc("t4_flush", ev(0, 2'b00, 2'b00, 0));
    issue_valid_E = '0; flush_E = 1'b0;
    cyc("t4_still_idle", ev(0, 2'b00, 2'b00, 0));
    use_rs_D = 1'b0; issue_valid_E = 2'b01; issue_dst_E[5:0] = 6'd7; issue_lat_E[5:0] = 6'd0;
    cyc("t4_lat0_issue", ev(0, 2'b00, 2'b00, 0));
    issue_valid_E = '0; use_rs_D = 1'b1; RsD = 6'd7; dst_D = 6'd7;
    cyc("t4_lat0_rdy", ev(1, 2'b01, 2'b01, 0));
    wb_ack_W = 2'b01;
    cyc("t4_ack_forward", ev(0, 2'b01, 2'b01, 0));
    wb_ack_W = '0; use_rs_D = 1'b0; dst_D = '0;
    cyc("t4_idle", ev(0, 2'b00, 2'b00, 0));

    // reset mid-operation, then a stray ack raises the sticky error
    issue_valid_E = 2'b01; issue_dst_E[5:0] = 6'd9; issue_lat_E[5:0] = 6'd3;
    cyc("t5_issue", ev(0, 2'b00, 2'b00, 0));
    issue_valid_E = '0;
    cyc("t5_cnt3", ev(0, 2'b01, 2'b00, 0));
    RST = 1'b1;
    cyc("t5_cnt2", ev(0, 2'b01, 2'b00, 0));
    RST = 1'b0; use_rs_D = 1'b1; RsD = 6'd9;
    cyc("t5_after_rst", ev(0, 2'b00, 2'b00, 0));
    use_rs_D = 1'b0; wb_ack_W = 2'b01;
    cyc("t5_stray_ack", ev(0, 2'b00, 2'b00, 0));
    wb_ack_W = '0;
    cyc("t5_err_set", ev(0, 2'b00, 2'b00, 1));
    for (int i = 0; i < 3; i++) cyc("t5_err_sticky", ev(0, 2'b00, 2'b00, 1));
    RST = 1'b1;
    cyc("t5_rst_cycle", ev(0, 2'b00, 2'b00, 1));
    RST = 1'b0;
    cyc("t5_err_clear", ev(0, 2'b00, 2'b00, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
